walu_seq: RTL and testbench
===========================

Name: walu_seq

Overview:
- Sequential, handshaked successor to the combinational walu operation set; same ten opcodes (add, sub, mult, bitand, bitor, bitxor, funclsl, funclsr, funcrl, funcrr).
- Generalised in width and multiplier throughput.
- Full 2*DATA_WIDTH product from an iterative multiplier.
- Sits between a valid/ready operand source (driver/sequencer side) and a valid/ready result sink (monitor/scoreboard side).

Parameters:
- DATA_WIDTH, 32, operand width; power of two, >= 4.
- MULT_BITS, 1, multiplier bits retired per cycle; must divide DATA_WIDTH; multiply takes DATA_WIDTH/MULT_BITS cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat.
- op  in  4  opcode, walu_pkg::op_t encoding (add=0 … funcrr=9).
- a  in  DATA_WIDTH  operand A.
- b  in  DATA_WIDTH  operand B; shift/rotate amount = b[log2(DATA_WIDTH)-1:0].
- out_valid  out  1  result beat valid.
- out_ready  in  1  sink accepts result.
- res  out  2*DATA_WIDTH  result.
- out_op  out  4  opcode of the result beat.
- err  out  1  result beat came from an illegal opcode (10..15).
- busy  out  1  multiply in progress.

Behaviour:
- Reset, asynchronous on rst_n low: FSM=IDLE, out_valid=0, res=0, out_op=0, err=0, busy=0, multiplier accumulator cleared.
- Reset during a multiply aborts it; no result beat is produced.
- After reset release: in_ready=1.
- Transfers:
  - Input transfer = in_valid & in_ready at a clk edge.
  - Output transfer = out_valid & out_ready at a clk edge.
- FSM states: IDLE, MUL.
- in_ready = (state==IDLE) & (!out_valid | out_ready). A beat can be accepted in the same cycle the pending result drains.
- Non-multiply ops, IDLE to output register, latency 1 cycle:
  - add: res[DATA_WIDTH:0] = a+b; res[DATA_WIDTH] = carry.
  - sub: res[DATA_WIDTH:0] = a-b; res[DATA_WIDTH] = borrow (1 when a<b unsigned).
  - bitand/bitor/bitxor: bitwise result in the low half.
  - funclsl/funclsr: logical shifts, zero fill.
  - funcrl/funcrr: rotates.
  - All bits of res above the defined width are 0.
- mult, accepted in IDLE:
  - Go to MUL; busy=1; in_ready=0.
  - Unsigned shift-add, MULT_BITS of b per cycle.
  - After exactly N=DATA_WIDTH/MULT_BITS cycles in MUL: res = full unsigned a*b; out_valid=1; return to IDLE; busy=0.
  - First out_valid occurs N+1 edges after acceptance, counting the acceptance edge.
  - Operands are captured at acceptance; later input changes are ignored.
- Illegal op (10..15): accepted, latency 1, res=0, err=1.
- Output hold: while out_valid & !out_ready, res, out_op and err stay stable.
  - A multiply whose last MUL cycle would overwrite a pending result stalls in MUL (busy stays 1) until the register is free.
  - A stall is possible only if the prior result was not drained; in_ready blocks new entry otherwise.
- Throughput: 1 beat/cycle for non-multiply ops with out_ready held high.
- Step counter width: clog2(N)+1; no wrap beyond N.

Optional Feature:
- Macro: WALU_SEQ_FLAGS_EN.
- Defined: adds output port flags, 4 bits {Z,N,C,V}, registered with res and held under back-pressure; reset value 0.
  - Z = low DATA_WIDTH bits of res all zero. For mult, Z covers the full 2*DATA_WIDTH product.
  - N = res[DATA_WIDTH-1].
  - C = carry (add) or borrow (sub); 0 otherwise.
  - V = signed overflow for add/sub; 0 otherwise.
- Undefined: port absent, no flag logic.

Test Plan (DATA_WIDTH=32, MULT_BITS=1 unless stated):
- Reset values: hold rst_n=0 → all outputs 0. Release → in_ready=1.
- Add: add a=FFFFFFFF, b=1, out_ready=1 → next cycle res=0x1_00000000, out_valid for 1 cycle. With flags: Z=1, C=1.
- Multiply: mult a=FFFFFFFF, b=FFFFFFFF → busy=1 for 32 cycles; out_valid on the 33rd edge; res=FFFFFFFE_00000001. Repeat with MULT_BITS=4: 8 cycles.
- Back-pressure: out_ready=0, send sub a=3, b=5 → res=0x1_FFFFFFFE held and in_ready=0. Assert out_ready together with a new in_valid (funcrr a=1, b=1) → both transfers in one cycle; next res=80000000.
- Illegal opcode and shift mask: op=12 → err=1, res=0. Then funclsl a=1, b=33 → res=2 (amount masked to 1).
- Abort: pull rst_n low at MUL cycle 10 → out_valid never asserts for that beat; after release a fresh add completes normally.

Source files
------------

// File: rtl/walu_seq.sv
// walu_seq: handshaked ten-op ALU with an iterative shift-add multiplier.
// Define WALU_SEQ_FLAGS_EN to add the registered {Z,N,C,V} flags output.

package walu_pkg;
   typedef enum logic [3:0] {
      OP_ADD     = 4'd0,
      OP_SUB     = 4'd1,
      OP_MULT    = 4'd2,
      OP_BITAND  = 4'd3,
      OP_BITOR   = 4'd4,
      OP_BITXOR  = 4'd5,
      OP_FUNCLSL = 4'd6,
      OP_FUNCLSR = 4'd7,
      OP_FUNCRL  = 4'd8,
      OP_FUNCRR  = 4'd9
   } op_t;
endpackage

module walu_seq
   import walu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MULT_BITS  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              op,
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] res,
   output logic [3:0]              out_op,
   output logic                    err,
   output logic                    busy
`ifdef WALU_SEQ_FLAGS_EN
   ,
   output logic [3:0]              flags
`endif
);
   localparam int W      = DATA_WIDTH;
   localparam int SHW    = $clog2(DATA_WIDTH);
   localparam int N      = DATA_WIDTH / MULT_BITS;
   localparam int STEP_W = $clog2(N) + 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

   typedef enum logic {IDLE, MUL} state_t;

   state_t            state;
   logic [2*W-1:0]    mcand;
   logic [2*W-1:0]    acc;
   logic [2*W-1:0]    partial;
   logic [2*W-1:0]    next_acc;
   logic [2*W-1:0]    alu_res;
   logic [W-1:0]      mplier;
   logic [STEP_W-1:0] step;
   logic [W:0]        sum_ext;
   logic [W:0]        diff_ext;
   logic [SHW-1:0]    amt;
   logic [SHW:0]      inv_amt;
   logic              alu_err;
   logic              out_free;
   logic              accept;
   logic              load_alu;
   logic              start_mul;
   logic              mul_done;

   assign out_free  = !out_valid || out_ready;
   assign in_ready  = (state == IDLE) && out_free;
   assign accept    = in_valid && in_ready;
   assign load_alu  = accept && (op != OP_MULT);
   assign start_mul = accept && (op == OP_MULT);
   assign mul_done  = (state == MUL) && (step == LAST_STEP) && out_free;
   assign amt       = b[SHW-1:0];
   // A rotate by zero shifts the wrapped half by the full width, which yields zero.
   assign inv_amt   = (SHW+1)'(W) - {1'b0, amt};

   always_comb begin
      sum_ext  = {1'b0, a} + {1'b0, b};
      diff_ext = {1'b0, a} - {1'b0, b};
      alu_res  = '0;
      alu_err  = 1'b0;
      case (op)
         OP_ADD:     alu_res[W:0]   = sum_ext;
         OP_SUB:     alu_res[W:0]   = diff_ext;
         OP_MULT:    alu_res        = '0;
         OP_BITAND:  alu_res[W-1:0] = a & b;
         OP_BITOR:   alu_res[W-1:0] = a | b;
         OP_BITXOR:  alu_res[W-1:0] = a ^ b;
         OP_FUNCLSL: alu_res[W-1:0] = a << amt;
         OP_FUNCLSR: alu_res[W-1:0] = a >> amt;
         OP_FUNCRL:  alu_res[W-1:0] = (a << amt) | (a >> inv_amt);
         OP_FUNCRR:  alu_res[W-1:0] = (a >> amt) | (a << inv_amt);
         default:    alu_err        = 1'b1;
      endcase
   end

   always_comb begin
      partial = '0;
      for (int i = 0; i < MULT_BITS; i++) begin
         if (mplier[i]) partial = partial + (mcand << i);
      end
      next_acc = acc + partial;
   end

   // The last multiplier step is folded into the result load, so it waits for a free output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         step      <= '0;
         out_valid <= 1'b0;
         res       <= '0;
         out_op    <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_mul) begin
                  mcand  <= {{W{1'b0}}, a};
                  mplier <= b;
                  acc    <= '0;
                  step   <= '0;
                  busy   <= 1'b1;
                  state  <= MUL;
               end
            end
            MUL: begin
               if (step != LAST_STEP) begin
                  acc    <= next_acc;
                  mcand  <= mcand << MULT_BITS;
                  mplier <= mplier >> MULT_BITS;
                  step   <= step + STEP_W'(1);
               end else if (out_free) begin
                  acc   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (load_alu) begin
            res       <= alu_res;
            out_op    <= op;
            err       <= alu_err;
            out_valid <= 1'b1;
         end else if (mul_done) begin
            res       <= next_acc;
            out_op    <= OP_MULT;
            err       <= 1'b0;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef WALU_SEQ_FLAGS_EN
   logic [3:0] alu_flags;

   always_comb begin
      alu_flags    = '0;
      alu_flags[3] = (alu_res[W-1:0] == '0);
      alu_flags[2] = alu_res[W-1];
      case (op)
         OP_ADD: begin
            alu_flags[1] = alu_res[W];
            alu_flags[0] = (a[W-1] == b[W-1]) && (alu_res[W-1] != a[W-1]);
         end
         OP_SUB: begin
            alu_flags[1] = alu_res[W];
            alu_flags[0] = (a[W-1] != b[W-1]) && (alu_res[W-1] != a[W-1]);
         end
         default: alu_flags[1:0] = 2'b00;
      endcase
   end

   // Flags follow the result register exactly, including hold under back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= '0;
      end else if (load_alu) begin
         flags <= alu_flags;
      end else if (mul_done) begin
         flags <= {(next_acc == '0), next_acc[W-1], 2'b00};
      end
   end
`endif

endmodule

// File: tb/tb_walu_seq.sv
// tb_walu_seq: directed and randomized checks of walu_seq against a behavioural model.
// Two instances: MULT_BITS=1 (main) and MULT_BITS=4 (multiply latency only).
module tb_walu_seq;
   import walu_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid, in_ready, out_valid, out_ready, err, busy;
   logic [3:0]    op, out_op;
   logic [W-1:0]  a, b;
   logic [63:0]   res;
   logic          in_valid_4, in_ready_4, out_valid_4, out_ready_4, err_4, busy_4;
   logic [3:0]    op_4, out_op_4;
   logic [W-1:0]  a_4, b_4;
   logic [63:0]   res_4;
`ifdef WALU_SEQ_FLAGS_EN
   logic [3:0]    flags, flags_4;
   logic [3:0]    exp_flags_q[$];
`endif

   int            checks = 0;
   int            failures = 0;
   bit            mon_en = 1'b0;
   logic [63:0]   exp_res_q[$];
   logic [3:0]    exp_op_q[$];
   logic          exp_err_q[$];
   bit            hold_pending = 1'b0;
   logic [63:0]   held_res;
   logic [3:0]    held_op;
   logic          held_err;

   walu_seq #(.DATA_WIDTH(32), .MULT_BITS(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .out_op(out_op), .err(err), .busy(busy)
`ifdef WALU_SEQ_FLAGS_EN
      , .flags(flags)
`endif
   );

   walu_seq #(.DATA_WIDTH(32), .MULT_BITS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_4), .in_ready(in_ready_4),
      .op(op_4), .a(a_4), .b(b_4), .out_valid(out_valid_4), .out_ready(out_ready_4),
      .res(res_4), .out_op(out_op_4), .err(err_4), .busy(busy_4)
`ifdef WALU_SEQ_FLAGS_EN
      , .flags(flags_4)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, expv);
      end
   endtask

   task automatic applyStimulus(input logic vld, input logic [3:0] o, input logic [31:0] x,
                                input logic [31:0] y, input logic rdy);
      in_valid  = vld;
      op        = o;
      a         = x;
      b         = y;
      out_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain wide arithmetic on the operation definitions.
   function automatic logic [63:0] model_res(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      int unsigned amt;
      logic [31:0] t;
      logic [63:0] r;
      amt = y % 32;
      r = '0;
      case (o)
         4'd0: r = {32'b0, x} + {32'b0, y};
         4'd1: r = ({32'b0, x} - {32'b0, y}) & 64'h1_FFFF_FFFF;
         4'd2: r = {32'b0, x} * {32'b0, y};
         4'd3: r = {32'b0, x & y};
         4'd4: r = {32'b0, x | y};
         4'd5: r = {32'b0, x ^ y};
         4'd6: begin t = x << amt; r = {32'b0, t}; end
         4'd7: begin t = x >> amt; r = {32'b0, t}; end
         4'd8: begin t = (amt == 0) ? x : ((x << amt) | (x >> (32 - amt))); r = {32'b0, t}; end
         4'd9: begin t = (amt == 0) ? x : ((x >> amt) | (x << (32 - amt))); r = {32'b0, t}; end
         default: r = '0;
      endcase
      return r;
   endfunction

`ifdef WALU_SEQ_FLAGS_EN
   function automatic logic [3:0] model_flags(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] r;
      longint sx, sy, s;
      logic z, n, c, v;
      r  = model_res(o, x, y);
      sx = longint'(signed'(x));
      sy = longint'(signed'(y));
      z  = (o == 4'd2) ? (r == 64'd0) : (r[31:0] == 32'd0);
      n  = r[31];
      c  = (o <= 4'd1) ? r[32] : 1'b0;
      v  = 1'b0;
      if (o <= 4'd1) begin
         s = (o == 4'd0) ? sx + sy : sx - sy;
         v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      return {z, n, c, v};
   endfunction
`endif

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   task automatic mult_latency(input bit use4, input logic [31:0] x, input logic [31:0] y,
                               input int exp_edges, input string tag);
      int edges;
      int busy_cnt;
      logic ov;
      logic [63:0] r;
      if (use4) begin
         in_valid_4 = 1'b1; op_4 = OP_MULT; a_4 = x; b_4 = y; out_ready_4 = 1'b1;
      end else begin
         applyStimulus(1'b1, OP_MULT, x, y, 1'b1);
      end
      tick();
      edges = 1;
      busy_cnt = use4 ? int'(busy_4) : int'(busy);
      checkOutput({tag, "_in_ready_low"}, 64'(use4 ? in_ready_4 : in_ready), 64'd0);
      if (use4) begin
         in_valid_4 = 1'b0; a_4 = $urandom; b_4 = $urandom;
      end else begin
         in_valid = 1'b0; a = $urandom; b = $urandom;
      end
      ov = use4 ? out_valid_4 : out_valid;
      while (!ov && edges < 200) begin
         tick();
         edges++;
         if (use4 ? busy_4 : busy) busy_cnt++;
         ov = use4 ? out_valid_4 : out_valid;
      end
      checkOutput({tag, "_latency"}, 64'(edges), 64'(exp_edges));
      checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_edges - 1));
      r = use4 ? res_4 : res;
      checkOutput({tag, "_res"}, r, model_res(OP_MULT, x, y));
      tick();
      checkOutput({tag, "_drained"}, 64'(use4 ? out_valid_4 : out_valid), 64'd0);
   endtask

   // Scoreboard: inputs and outputs are stable at the falling edge, so transfers are predicted there.
   always @(negedge clk) begin
      if (mon_en) begin
         if (hold_pending) begin
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_res", res, held_res);
            checkOutput("hold_op", 64'(out_op), 64'(held_op));
            checkOutput("hold_err", 64'(err), 64'(held_err));
         end
         if (out_valid && out_ready) begin
            if (exp_res_q.size() == 0) begin
               checkOutput("unexpected_beat", 64'(out_valid), 64'd0);
            end else begin
               checkOutput("sb_res", res, exp_res_q.pop_front());
               checkOutput("sb_op", 64'(out_op), 64'(exp_op_q.pop_front()));
               checkOutput("sb_err", 64'(err), 64'(exp_err_q.pop_front()));
`ifdef WALU_SEQ_FLAGS_EN
               checkOutput("sb_flags", 64'(flags), 64'(exp_flags_q.pop_front()));
`endif
            end
         end
         hold_pending = out_valid && !out_ready;
         held_res     = res;
         held_op      = out_op;
         held_err     = err;
         if (in_valid && in_ready) begin
            exp_res_q.push_back(model_res(op, a, b));
            exp_op_q.push_back(op);
            exp_err_q.push_back(op > 4'd9);
`ifdef WALU_SEQ_FLAGS_EN
            exp_flags_q.push_back(model_flags(op, a, b));
`endif
         end
      end
   end

   initial begin
      int cnt;
      int r;
      logic [3:0] o;
      logic [31:0] x, y;

      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      in_valid_4 = 1'b0; op_4 = 4'd0; a_4 = '0; b_4 = '0; out_ready_4 = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_res", res, 64'd0);
      checkOutput("rst_out_op", 64'(out_op), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
`ifdef WALU_SEQ_FLAGS_EN
      checkOutput("rst_flags", 64'(flags), 64'd0);
`endif
      rst_n = 1'b1;
      #1;
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_in_ready_4", 64'(in_ready_4), 64'd1);

      applyStimulus(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
      tick();
      in_valid = 1'b0;
      checkOutput("add_valid", 64'(out_valid), 64'd1);
      checkOutput("add_res", res, 64'h1_0000_0000);
      checkOutput("add_op", 64'(out_op), 64'd0);
`ifdef WALU_SEQ_FLAGS_EN
      checkOutput("add_flags", 64'(flags), 64'b1010);
`endif
      tick();
      checkOutput("add_one_cycle", 64'(out_valid), 64'd0);

      mult_latency(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mul1_max");
      checkOutput("mul1_max_const", model_res(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
      mult_latency(1'b0, $urandom, $urandom, 33, "mul1_rand");

      applyStimulus(1'b1, OP_SUB, 32'd3, 32'd5, 1'b0);
      tick();
      in_valid = 1'b0;
      checkOutput("bp_res", res, 64'h1_FFFF_FFFE);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      repeat (2) tick();
      checkOutput("bp_hold_res", res, 64'h1_FFFF_FFFE);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      applyStimulus(1'b1, OP_FUNCRR, 32'd1, 32'd1, 1'b1);
      #1;
      checkOutput("bp_ready_drain", 64'(in_ready), 64'd1);
      tick();
      checkOutput("bp_rr_res", res, 64'h0000_0000_8000_0000);
      checkOutput("bp_rr_op", 64'(out_op), 64'd9);

      applyStimulus(1'b1, 4'd12, $urandom, $urandom, 1'b1);
      tick();
      checkOutput("ill_err", 64'(err), 64'd1);
      checkOutput("ill_res", res, 64'd0);
      checkOutput("ill_op", 64'(out_op), 64'd12);
      applyStimulus(1'b1, OP_FUNCLSL, 32'd1, 32'd33, 1'b1);
      tick();
      in_valid = 1'b0;
      checkOutput("lsl_mask_res", res, 64'd2);
      checkOutput("lsl_mask_err", 64'(err), 64'd0);
      tick();

      applyStimulus(1'b1, OP_MULT, $urandom, $urandom, 1'b1);
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_valid", 64'(out_valid), 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      cnt = 0;
      repeat (40) begin
         tick();
         if (out_valid) cnt++;
      end
      checkOutput("abort_no_beat", 64'(cnt), 64'd0);
      applyStimulus(1'b1, OP_ADD, 32'd5, 32'd7, 1'b1);
      tick();
      in_valid = 1'b0;
      checkOutput("post_abort_add", res, 64'd12);
      tick();

      mult_latency(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, "mul4_max");
      mult_latency(1'b1, $urandom, $urandom, 9, "mul4_rand");

      mon_en = 1'b1;
      for (int cyc = 0; cyc < 800; cyc++) begin
         r = $urandom_range(0, 19);
         o = (r < 18) ? 4'(r % 10) : 4'($urandom_range(10, 15));
         x = pick_val();
         y = pick_val();
         applyStimulus($urandom_range(0, 9) < 7, o, x, y, $urandom_range(0, 9) < 7);
         tick();
      end
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
      for (int k = 0; k < 100 && (exp_res_q.size() != 0 || busy); k++) tick();
      checkOutput("drain_empty", 64'(exp_res_q.size()), 64'd0);
      tick();
      mon_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
